// File: rtl/gumnut_exec_pkg.sv
// Shared types for the Gumnut execute/writeback unit.
// ALU function codes, writeback selects and load-wait FSM states.
package gumnut_exec_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    ADDC = 4'd1,
    SUB  = 4'd2,
    SUBC = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    MASK = 4'd7,
    SHL  = 4'd8,
    SHR  = 4'd9,
    ROL  = 4'd10,
    ROR  = 4'd11
  } alu_fn_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PORT = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/gumnut_alu_p.sv
// Combinational Gumnut ALU, DATA_W wide.
// o_vld is low for undefined function codes so the caller keeps its flags.
module gumnut_alu_p
  import gumnut_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CW     = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_c,
  input  logic [3:0]        i_fn,
  input  logic [CW-1:0]     i_cnt,
  output logic [DATA_W-1:0] o_res,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_vld
);

  logic              w_cin;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W:0]   w_shr;
  logic [DATA_W-1:0] w_rol;
  logic [DATA_W-1:0] w_ror;

  assign w_cin = i_c & ((i_fn == ADDC) | (i_fn == SUBC));
  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + (DATA_W+1)'(w_cin);
  // top bit of the wide difference is the unsigned borrow
  assign w_dif = {1'b0, i_a} - {1'b0, i_b} - (DATA_W+1)'(w_cin);
  assign w_shl = {1'b0, i_a} << i_cnt;
  assign w_shr = {i_a, 1'b0} >> i_cnt;
  assign w_rol = (i_a << i_cnt) | (i_a >> (DATA_W - int'(i_cnt)));
  assign w_ror = (i_a >> i_cnt) | (i_a << (DATA_W - int'(i_cnt)));

  always_comb begin
    o_res   = '0;
    o_carry = 1'b0;
    o_vld   = 1'b1;
    unique case (i_fn)
      ADD, ADDC: {o_carry, o_res} = w_sum;
      SUB, SUBC: {o_carry, o_res} = w_dif;
      AND:       o_res = i_a & i_b;
      OR:        o_res = i_a | i_b;
      XOR:       o_res = i_a ^ i_b;
      MASK:      o_res = i_a & ~i_b;
      SHL:       {o_carry, o_res} = w_shl;
      SHR: begin
        o_res   = w_shr[DATA_W:1];
        o_carry = w_shr[0];
      end
      ROL:       o_res = w_rol;
      ROR:       o_res = w_ror;
      default:   o_vld = 1'b0;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/gumnut_exec_unit.sv
// Gumnut execute/writeback: register bank, ALU, flags, load-wait FSM.
// Define EXEC_TIMEOUT_EN to bound the load wait by TIMEOUT_CYC cycles.
module gumnut_exec_unit
  import gumnut_exec_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 16,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [RW-1:0]     rs_i,
  input  logic [RW-1:0]     rs2_i,
  input  logic [RW-1:0]     rd_i,
  input  logic [DATA_W-1:0] immed_i,
  input  logic              op2_sel_i,
  input  logic [3:0]        alu_fn_i,
  input  logic [CW-1:0]     count_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              reg_we_i,
  input  logic              flag_we_i,
  output logic              ld_req_o,
  output logic              ld_port_o,
  output logic [ADDR_W-1:0] ld_addr_o,
  input  logic [DATA_W-1:0] ld_dat_i,
  input  logic              ld_ack_i,
  output logic [DATA_W-1:0] rs_dat_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              err_o
);

  if (ADDR_W > DATA_W || DATA_W < 4 || NUM_REGS < 2 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("gumnut_exec_unit: illegal parameter set");
  end

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_carry;
  logic              r_zero;
  logic [ADDR_W-1:0] r_ld_addr;
  logic              r_ld_port;
  logic [RW-1:0]     r_ld_rd;
  logic              r_ld_we;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b_reg;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_res;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_alu_vld;
  logic              w_accept;
  logic              w_ld_issue;
  logic              w_ack;
  logic              w_to;
  logic              w_flag_en;
  logic              w_wr_en;
  logic [RW-1:0]     w_wr_idx;
  logic [DATA_W-1:0] w_wr_dat;

  assign w_a     = (rs_i == '0) ? '0 : r_regs[rs_i];
  assign w_b_reg = (rs2_i == '0) ? '0 : r_regs[rs2_i];
  assign w_b     = op2_sel_i ? immed_i : w_b_reg;

  gumnut_alu_p #(
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_c     (r_carry),
    .i_fn    (alu_fn_i),
    .i_cnt   (count_i),
    .o_res   (w_res),
    .o_carry (w_alu_c),
    .o_zero  (w_alu_z),
    .o_vld   (w_alu_vld)
  );

  assign issue_ready_o = (r_state == IDLE);
  assign ld_req_o      = (r_state == WAIT);
  assign w_accept      = issue_valid_i & issue_ready_o;
  assign w_ld_issue    = w_accept &
                         ((wb_sel_i == WB_MEM) | (wb_sel_i == WB_PORT));
  assign w_ack         = ld_req_o & ld_ack_i;
  assign w_flag_en     = w_accept & flag_we_i & w_alu_vld &
                         ((wb_sel_i == WB_ALU) | (wb_sel_i == WB_NONE));

`ifdef EXEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // ack in the final wait cycle takes priority over the timeout
  assign w_to = ld_req_o & ~ld_ack_i &
                (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= ld_req_o ? r_to_cnt + 1'b1 : '0;
      if (w_to) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_to  = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_ld_issue) w_next = WAIT;
      WAIT: if (w_ack | w_to) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = rd_i;
    w_wr_dat = w_res;
    if (w_accept & (wb_sel_i == WB_ALU) & reg_we_i) begin
      w_wr_en = 1'b1;
    end else if (w_ack & r_ld_we) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_ld_rd;
      w_wr_dat = ld_dat_i;
    end
    if (w_wr_idx == '0) w_wr_en = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= w_wr_dat;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_flag_en) begin
      r_carry <= w_alu_c;
      r_zero  <= w_alu_z;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ld_addr <= '0;
      r_ld_port <= 1'b0;
      r_ld_rd   <= '0;
      r_ld_we   <= 1'b0;
    end else if (w_ld_issue) begin
      r_ld_addr <= w_a[ADDR_W-1:0] + immed_i[ADDR_W-1:0];
      r_ld_port <= (wb_sel_i == WB_PORT);
      r_ld_rd   <= rd_i;
      r_ld_we   <= reg_we_i;
    end
  end

  assign ld_addr_o = r_ld_addr;
  assign ld_port_o = r_ld_port;
  assign rs_dat_o  = w_a;
  assign carry_o   = r_carry;
  assign zero_o    = r_zero;

endmodule

// File: tb/tb_gumnut_exec_unit.sv
// Directed bench for gumnut_exec_unit (8-bit, 8 registers).
// Timeout steps are active when EXEC_TIMEOUT_EN is defined.
module tb_gumnut_exec_unit;
  import gumnut_exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [2:0] rs = '0;
  logic [2:0] rs2 = '0;
  logic [2:0] rd = '0;
  logic [7:0] immed = '0;
  logic       op2_sel = 1'b0;
  logic [3:0] alu_fn = '0;
  logic [2:0] count = '0;
  logic [1:0] wb_sel = '0;
  logic       reg_we = 1'b0;
  logic       flag_we = 1'b0;
  logic       ld_req;
  logic       ld_port;
  logic [7:0] ld_addr;
  logic [7:0] ld_dat = '0;
  logic       ld_ack = 1'b0;
  logic [7:0] rs_dat;
  logic       carry;
  logic       zero;
  logic       err;

  int checks = 0;
  int failures = 0;

  gumnut_exec_unit #(
    .DATA_W      (8),
    .NUM_REGS    (8),
    .ADDR_W      (8),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .rs_i          (rs),
    .rs2_i         (rs2),
    .rd_i          (rd),
    .immed_i       (immed),
    .op2_sel_i     (op2_sel),
    .alu_fn_i      (alu_fn),
    .count_i       (count),
    .wb_sel_i      (wb_sel),
    .reg_we_i      (reg_we),
    .flag_we_i     (flag_we),
    .ld_req_o      (ld_req),
    .ld_port_o     (ld_port),
    .ld_addr_o     (ld_addr),
    .ld_dat_i      (ld_dat),
    .ld_ack_i      (ld_ack),
    .rs_dat_o      (rs_dat),
    .carry_o       (carry),
    .zero_o        (zero),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic [2:0] d,
                       input logic [2:0] s, input logic [2:0] s2,
                       input logic [7:0] im, input logic sel,
                       input logic [2:0] c, input logic [1:0] wb,
                       input logic we, input logic fwe);
    alu_fn = f; rd = d; rs = s; rs2 = s2; immed = im;
    op2_sel = sel; count = c; wb_sel = wb;
    reg_we = we; flag_we = fwe; issue_valid = 1'b1;
  endtask

  task automatic iss(input logic [3:0] f, input logic [2:0] d,
                     input logic [2:0] s, input logic [2:0] s2,
                     input logic [7:0] im, input logic sel,
                     input logic [2:0] c, input logic [1:0] wb,
                     input logic we, input logic fwe);
    @(negedge clk);
    drive(f, d, s, s2, im, sel, c, wb, we, fwe);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic rdchk(input logic [2:0] idx, input logic [7:0] exp,
                       input string tag);
    rs = idx;
    #1;
    chk(tag, 32'(rs_dat), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_ldreq", 32'(ld_req), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rdchk(3'd1, 8'h00, "rst_r1");

    iss(ADD, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd1, 8'h05, "add_r1");
    chk("add_c", 32'(carry), 32'd0);
    chk("add_z", 32'(zero), 32'd0);

    iss(ADD, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    iss(ADD, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd2, 8'h00, "addwrap_r2");
    chk("addwrap_c", 32'(carry), 32'd1);
    chk("addwrap_z", 32'(zero), 32'd1);

    iss(ADDC, 3'd3, 3'd0, 3'd0, 8'h00, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd3, 8'h01, "addc_r3");
    chk("addc_c", 32'(carry), 32'd0);

    iss(SUB, 3'd4, 3'd0, 3'd0, 8'h01, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd4, 8'hFF, "sub_r4");
    chk("sub_borrow", 32'(carry), 32'd1);

    iss(ADD, 3'd1, 3'd0, 3'd0, 8'h03, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    chk("pre_shr_c", 32'(carry), 32'd0);
    iss(SHR, 3'd1, 3'd1, 3'd0, 8'h00, 1'b1, 3'd1, 2'd0, 1'b1, 1'b1);
    rdchk(3'd1, 8'h01, "shr_r1");
    chk("shr_c", 32'(carry), 32'd1);

    iss(ADD, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0);
    rdchk(3'd0, 8'h00, "r0_zero");

    iss(ADD, 3'd5, 3'd4, 3'd3, 8'h00, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd5, 8'h00, "addrr_r5");
    chk("addrr_c", 32'(carry), 32'd1);
    chk("addrr_z", 32'(zero), 32'd1);

    iss(MASK, 3'd6, 3'd4, 3'd0, 8'h0F, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd6, 8'hF0, "mask_r6");
    chk("mask_c", 32'(carry), 32'd0);

    iss(SHL, 3'd6, 3'd6, 3'd0, 8'h00, 1'b1, 3'd4, 2'd0, 1'b1, 1'b1);
    rdchk(3'd6, 8'h00, "shl_r6");
    chk("shl_c", 32'(carry), 32'd1);
    chk("shl_z", 32'(zero), 32'd1);

    iss(ROR, 3'd7, 3'd1, 3'd0, 8'h00, 1'b1, 3'd1, 2'd0, 1'b1, 1'b1);
    rdchk(3'd7, 8'h80, "ror_r7");
    chk("ror_c", 32'(carry), 32'd0);
    chk("ror_z", 32'(zero), 32'd0);

    iss(4'd12, 3'd7, 3'd1, 3'd0, 8'h00, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    rdchk(3'd7, 8'h00, "undef_r7");
    chk("undef_z_kept", 32'(zero), 32'd0);

    iss(SUB, 3'd2, 3'd0, 3'd0, 8'h01, 1'b1, 3'd0, 2'd3, 1'b1, 1'b1);
    chk("cmp_c", 32'(carry), 32'd1);
    rdchk(3'd2, 8'h00, "cmp_nowb_r2");

    iss(ADD, 3'd1, 3'd0, 3'd0, 8'h10, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(ADD, 3'd6, 3'd1, 3'd0, 8'h04, 1'b1, 3'd0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    drive(ADD, 3'd7, 3'd0, 3'd0, 8'h33, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    chk("ld_ready", 32'(issue_ready), 32'd0);
    chk("ld_req", 32'(ld_req), 32'd1);
    chk("ld_addr", 32'(ld_addr), 32'h14);
    chk("ld_port", 32'(ld_port), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("ld_req_hold", 32'(ld_req), 32'd1);
    end
    ld_ack = 1'b1;
    ld_dat = 8'hA5;
    issue_valid = 1'b0;
    @(negedge clk);
    ld_ack = 1'b0;
    chk("ld_done_ready", 32'(issue_ready), 32'd1);
    chk("ld_done_req", 32'(ld_req), 32'd0);
    rdchk(3'd6, 8'hA5, "ld_r6");
    rdchk(3'd7, 8'h00, "wait_noaccept_r7");
    chk("ld_c_kept", 32'(carry), 32'd1);
    chk("ld_z_kept", 32'(zero), 32'd0);
    chk("ld_no_err", 32'(err), 32'd0);

    @(negedge clk);
    drive(ADD, 3'd3, 3'd1, 3'd0, 8'hF0, 1'b1, 3'd0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    chk("fast_addr", 32'(ld_addr), 32'h00);
    chk("fast_req", 32'(ld_req), 32'd1);
    ld_ack = 1'b1;
    ld_dat = 8'h3C;
    @(negedge clk);
    ld_ack = 1'b0;
    chk("fast_ready", 32'(issue_ready), 32'd1);
    rdchk(3'd3, 8'h3C, "fast_r3");

    ld_ack = 1'b1;
    ld_dat = 8'h99;
    @(negedge clk);
    ld_ack = 1'b0;
    rdchk(3'd3, 8'h3C, "idle_ack_r3");
    chk("idle_ack_ready", 32'(issue_ready), 32'd1);

    @(negedge clk);
    drive(ADD, 3'd5, 3'd0, 3'd0, 8'h22, 1'b1, 3'd0, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    chk("port_flag", 32'(ld_port), 32'd1);
    chk("port_addr", 32'(ld_addr), 32'h22);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wait_req", 32'(ld_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_ready", 32'(issue_ready), 32'd1);
    ld_ack = 1'b1;
    ld_dat = 8'h5A;
    @(negedge clk);
    ld_ack = 1'b0;
    rdchk(3'd5, 8'h00, "rst_wait_r5");

`ifdef EXEC_TIMEOUT_EN
    @(negedge clk);
    drive(ADD, 3'd4, 3'd0, 3'd0, 8'h30, 1'b1, 3'd0, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_still_wait", 32'(issue_ready), 32'd0);
    @(negedge clk);
    chk("to_ready", 32'(issue_ready), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    ld_ack = 1'b1;
    ld_dat = 8'hEE;
    @(negedge clk);
    ld_ack = 1'b0;
    rdchk(3'd4, 8'h00, "to_r4");
    chk("to_err_sticky", 32'(err), 32'd1);
`else
    chk("no_to_err", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
